ex_muldiv_unit: RTL

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/mips_pkg.sv | 18 +
 rtl/muldiv_core.sv | 42 ++++
 rtl/ex_muldiv_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: multiply/divide op codes and sequencer state encodings shared by the EX stage.
package mips_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;
  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one shift-add multiply or restoring-divide step per cycle on unsigned magnitudes.
// Multiply leaves the product in hi:lo; divide leaves remainder in hi and quotient in lo.
module muldiv_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic [DATA_W-1:0] ld_hi,
  input  logic [DATA_W-1:0] ld_lo,
  input  logic [DATA_W-1:0] ld_b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [DATA_W-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic [DATA_W:0] sum, rem, dif;
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem  = {hi_q, lo_q[DATA_W-1]};
    dif  = rem - {1'b0, b_q};
    hi_d = div ? (dif[DATA_W] ? rem[DATA_W-1:0] : dif[DATA_W-1:0]) : sum[DATA_W:1];
    lo_d = div ? {lo_q[DATA_W-2:0], ~dif[DATA_W]} : {sum[0], lo_q[DATA_W-1:1]};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= ld_hi;
      lo_q <= ld_lo;
      b_q  <= ld_b;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage HI/LO unit sequencing iterative MULT/DIV, MTxx writes and MFxx reads.
// The issuing MULT/DIV is held in EX by o_stall; the o_done cycle releases it without re-accepting.
module ex_muldiv_unit import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_read_data,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  md_op_e            op;
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, c_hi, c_lo, a_mag, b_mag, ld_hi, ld_lo;
  logic [2*DATA_W-1:0] prod;
  logic done_q, done_d, neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
  logic load, step, iter, is_div, sgn, a_neg, b_neg, dz;
  assign op     = md_op_e'(i_op);
  assign iter   = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign is_div = op inside {MD_DIV, MD_DIVU};
  assign sgn    = op inside {MD_MULT, MD_DIV};
  assign a_neg  = sgn & i_rs_data[DATA_W-1];
  assign b_neg  = sgn & i_rt_data[DATA_W-1];
  assign a_mag  = a_neg ? -i_rs_data : i_rs_data;
  assign b_mag  = b_neg ? -i_rt_data : i_rt_data;
  assign dz     = is_div && i_rt_data == '0;
  // Divide by zero preloads the final HI/LO and goes straight to FIXUP with no sign correction.
  assign ld_hi  = dz ? i_rs_data : '0;
  assign ld_lo  = dz ? '1 : a_mag;
  assign prod   = {c_hi, c_lo};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      MD_IDLE: if (i_valid && !i_flush) begin
        if (op == MD_MTHI) hi_d = i_rs_data;
        if (op == MD_MTLO) lo_d = i_rs_data;
        if (iter && !done_q) begin
          load    = 1'b1;
          neg_d   = !dz && (a_neg ^ b_neg);
          rneg_d  = !dz && a_neg;
          div_d   = is_div;
          cnt_d   = '0;
          state_d = dz ? MD_FIXUP : MD_RUN;
        end
      end
      MD_RUN: begin
        step    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = cnt_q == CNT_W'(DATA_W-1) ? MD_FIXUP : MD_RUN;
      end
      MD_FIXUP: begin
        if (div_q) begin
          lo_d = neg_q ? -c_lo : c_lo;
          hi_d = rneg_q ? -c_hi : c_hi;
        end else
          {hi_d, lo_d} = neg_q ? -prod : prod;
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (i_flush) begin
      state_d = MD_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
    end
  end
  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .div   (div_q),
    .ld_hi (ld_hi),
    .ld_lo (ld_lo),
    .ld_b  (b_mag),
    .hi    (c_hi),
    .lo    (c_lo)
  );
  assign o_stall     = i_valid && (state_q != MD_IDLE || (iter && !done_q && !i_flush));
  assign o_busy      = state_q != MD_IDLE;
  assign o_done      = done_q;
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_read_data = (state_q == MD_IDLE && i_valid) ?
                       (op == MD_MFHI ? hi_q : op == MD_MFLO ? lo_q : '0) : '0;
endmodule
